// File: rtl/typedefs_v2.sv
// Shared types for the accumulator CPU: ALU opcodes, sequencer phases and
// the helper that classifies opcodes which read memory into the accumulator.
package typedefs_v2;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Eight instruction phases in execution order, plus the terminal halt state.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } seq_state_t;

  // Opcodes that fetch an operand and load the accumulator with the ALU result.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/seq_control_if.sv
// Memory bus between the sequencer (master) and program/data memory (slave).
// With SEQ_STALL_EN defined the bus carries the mem_ready handshake.
interface seq_control_if #(
  parameter int PC_W = 5
) ();

  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [7:0]      data_in;
`ifdef SEQ_STALL_EN
  logic            mem_ready;
`endif

  modport master (
    output mem_addr, mem_rd, mem_wr,
`ifdef SEQ_STALL_EN
    input  data_in, mem_ready
`else
    input  data_in
`endif
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr,
`ifdef SEQ_STALL_EN
    output data_in, mem_ready
`else
    output data_in
`endif
  );

endinterface

// File: rtl/seq_control_pc.sv
// Program counter: PC_W-bit register with synchronous reset, load and
// increment. A load (JMP) takes priority over an increment.
module seq_pc #(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Counter update; addition wraps modulo 2**PC_W.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk) begin
    if (rst)       pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/seq_control.sv
// Instruction sequencer for the 8-bit accumulator CPU. Walks a fixed
// 8-phase FSM per instruction, drives memory strobes, the accumulator load
// enable and the ALU opcode, and steps the program counter.
// Optional feature macro: SEQ_STALL_EN adds the mem_ready handshake; the FSM
// then holds in any strobing phase while memory is not ready.
module seq_control
  import typedefs_v2::*;
#(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  seq_control_if.master   mem,
  input  logic            zero,
  output opcode_t         opcode,
  output logic            load_ac,
  output logic [PC_W-1:0] pc,
  output logic            halt
);

  seq_state_t      state_q, state_d;
  logic [7:0]      ir;
  logic [PC_W-1:0] operand;
  logic            aluop;
  logic            rd_c, wr_c, ld_c, halt_c;
  logic            advance;
  logic            pc_inc, pc_load;

  assign opcode  = opcode_t'(ir[7:5]);
  assign operand = PC_W'(ir[4:0]);
  assign aluop   = is_aluop(opcode);

`ifdef SEQ_STALL_EN
  // A strobing phase waits for memory; strobe-free phases never stall.
  assign advance = mem.mem_ready | ~(rd_c | wr_c);
`else
  assign advance = 1'b1;
`endif

  // Moore output decode from the current phase and the instruction register.
  // NOTE: every output gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    ld_c   = 1'b0;
    halt_c = 1'b0;
    case (state_q)
      S_INST_FETCH, S_INST_LOAD, S_IDLE: rd_c = 1'b1;
      S_OP_FETCH:                        rd_c = aluop;
      S_ALU_OP: begin
        rd_c = aluop;
        ld_c = aluop;
      end
      S_STORE: begin
        rd_c = aluop;
        ld_c = aluop;
        wr_c = (opcode == STO);
      end
      S_HALTED:                          halt_c = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_rd = rd_c;
  assign mem.mem_wr = wr_c;
  assign load_ac    = ld_c;
  assign halt       = halt_c;

  // Instruction-fetch phases address the PC; operand phases and HALTED the IR.
  assign mem.mem_addr = (state_q inside {S_INST_ADDR, S_INST_FETCH, S_INST_LOAD, S_IDLE})
                        ? pc : operand;

  // Next-phase selection; a stalled cycle keeps the current phase.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        S_INST_ADDR:  state_d = S_INST_FETCH;
        S_INST_FETCH: state_d = S_INST_LOAD;
        S_INST_LOAD:  state_d = S_IDLE;
        S_IDLE:       state_d = S_OP_ADDR;
        S_OP_ADDR:    state_d = (opcode == HLT) ? S_HALTED : S_OP_FETCH;
        S_OP_FETCH:   state_d = S_ALU_OP;
        S_ALU_OP:     state_d = S_STORE;
        S_STORE:      state_d = S_INST_ADDR;
        S_HALTED:     state_d = S_HALTED;
        default:      state_d = S_INST_ADDR;
      endcase
    end
  end

  // Phase register; reset overrides stalls and every in-flight phase.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INST_ADDR;
    else     state_q <= state_d;
  end

  // Instruction register, captured once per instruction at the end of INST_LOAD.
  // NOTE: IR is reset to zero so the opcode reads as HLT until the first fetch.
  always_ff @(posedge clk) begin
    if (rst)                                  ir <= 8'h00;
    else if (state_q == S_INST_LOAD && advance) ir <= mem.data_in;
  end

  // PC step after OP_ADDR, SKZ skip and JMP load in ALU_OP; zero matters only here.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    if (advance) begin
      if (state_q == S_OP_ADDR)                          pc_inc  = 1'b1;
      if (state_q == S_ALU_OP && opcode == SKZ && zero)  pc_inc  = 1'b1;
      if (state_q == S_ALU_OP && opcode == JMP)          pc_load = 1'b1;
    end
  end

  seq_pc #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (operand),
    .pc       (pc)
  );

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control. The reference model works per
// instruction: from the opcode, operand, zero flag and starting PC it derives
// the expected outputs for each of the eight clocks and the next PC.
module tb_seq_control;
  import typedefs_v2::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       zero;
  opcode_t    opcode;
  logic       load_ac;
  logic [4:0] pc;
  logic       halt;

  seq_control_if #(.PC_W(5)) bus ();

  seq_control #(.PC_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (bus),
    .zero    (zero),
    .opcode  (opcode),
    .load_ac (load_ac),
    .pc      (pc),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: PC at the start of the next instruction, last loaded opcode.
  logic [4:0] mpc;
  logic [2:0] mop;

  function automatic logic [16:0] observed();
    return {opcode, bus.mem_addr, bus.mem_rd, bus.mem_wr, load_ac, pc, halt};
  endfunction

  // Apply a reset pulse; check the reset values while rst is still high.
  task automatic do_reset(input string tag);
    logic [16:0] got;
    @(negedge clk);
    rst = 1'b1;
    zero = 1'($urandom);
    @(negedge clk);
    got = observed();
    n_checks++;
    if (got !== 17'h0) begin
      n_fail++;
      $display("FAIL %s reset_state: got %h expected %h", tag, got, 17'h0);
    end
    rst = 1'b0;
    mpc = 5'd0;
    mop = 3'd0;
  endtask

  // Run one non-HLT instruction from INST_ADDR, checking each clock.
  // n_cyc < 8 stops early (for mid-instruction reset); stall_k/stall_n hold
  // mem_ready low for stall_n extra clocks in phase stall_k.
  task automatic run_instr(input logic [7:0] instr, input logic z, input int n_cyc,
                           input int stall_k, input int stall_n, input string tag);
    logic [2:0]  op;
    logic [4:0]  opnd, pc0, pc1, pcn;
    logic        alu;
    logic        e_rd, e_wr, e_ld;
    logic [4:0]  e_addr, e_pc;
    logic [2:0]  e_op;
    logic [16:0] exp_v, got;
    int          reps;
    op   = instr[7:5];
    opnd = instr[4:0];
    alu  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    pc0  = mpc;
    pc1  = pc0 + 5'd1;
    if (op == 3'd7)            pcn = opnd;
    else if (op == 3'd1 && z)  pcn = pc0 + 5'd2;
    else                       pcn = pc1;
    bus.data_in = instr;
    for (int k = 0; k < n_cyc; k++) begin
      zero   = (k == 6) ? z : 1'($urandom);
      e_rd   = (k >= 1 && k <= 3) || (k >= 5 && alu);
      e_ld   = (k >= 6) && alu;
      e_wr   = (k == 7) && (op == 3'd6);
      e_addr = (k < 4) ? pc0 : opnd;
      e_pc   = (k <= 4) ? pc0 : ((k <= 6) ? pc1 : pcn);
      e_op   = (k < 3) ? mop : op;
      exp_v  = {e_op, e_addr, e_rd, e_wr, e_ld, e_pc, 1'b0};
      reps   = (k == stall_k) ? stall_n + 1 : 1;
      for (int r = 0; r < reps; r++) begin
`ifdef SEQ_STALL_EN
        bus.mem_ready = (r < reps - 1) ? 1'b0 : 1'b1;
`endif
        got = observed();
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL %s instr=%h cycle=%0d rep=%0d: got %h expected %h",
                   tag, instr, k, r, got, exp_v);
        end
        @(negedge clk);
      end
    end
`ifdef SEQ_STALL_EN
    bus.mem_ready = 1'b1;
`endif
    if (n_cyc == 8) mpc = pcn;
    mop = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("reset");
    run_instr(8'hA3, 1'b0, 8, -1, 0, "reset_first");   // LDA 3 from PC 0
  endtask

  task automatic test_add();
    run_instr(8'hE3, 1'b0, 8, -1, 0, "add_jmp3");
    run_instr(8'h4A, 1'b1, 8, -1, 0, "add");
  endtask

  task automatic test_skz();
    run_instr(8'hE7, 1'b0, 8, -1, 0, "skz_jmp7");
    run_instr(8'h20, 1'b1, 8, -1, 0, "skz_taken");
    run_instr(8'hE7, 1'b0, 8, -1, 0, "skz_jmp7b");
    run_instr(8'h20, 1'b0, 8, -1, 0, "skz_not_taken");
    run_instr(8'hFF, 1'b0, 8, -1, 0, "skz_jmp31");
    run_instr(8'h20, 1'b1, 8, -1, 0, "skz_wrap");
    run_instr(8'h81, 1'b0, 8, -1, 0, "skz_after");     // starts at PC 1
  endtask

  task automatic test_jmp_sto();
    run_instr(8'hE5, 1'b1, 8, -1, 0, "jmp5");
    run_instr(8'hC9, 1'b1, 8, -1, 0, "sto9");
    run_instr(8'h64, 1'b0, 8, -1, 0, "after_sto");
  endtask

  task automatic test_back_to_back();
    logic [7:0] instr;
    for (int i = 0; i < 40; i++) begin
      instr = 8'($urandom);
      if (instr[7:5] == 3'd0) instr[7:5] = 3'($urandom_range(7, 1));
      run_instr(instr, 1'($urandom), 8, -1, 0, "random");
    end
  endtask

`ifdef SEQ_STALL_EN
  task automatic test_stall();
    run_instr(8'h47, 1'b0, 8, 1, 3, "stall_fetch");
    run_instr(8'hAA, 1'b0, 8, 5, 2, "stall_opfetch");
    run_instr(8'h31, 1'b1, 8, -1, 0, "after_stall");
  endtask
`endif

  task automatic test_mid_reset();
    logic [16:0] got;
    run_instr(8'hE3, 1'b0, 8, -1, 0, "midrst_jmp3");
    run_instr(8'h4A, 1'b0, 6, -1, 0, "midrst_add");
    rst  = 1'b1;                                       // during ALU_OP
    zero = 1'b1;
    @(negedge clk);
    got = observed();
    n_checks++;
    if (got !== 17'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", got, 17'h0);
    end
    rst = 1'b0;
    mpc = 5'd0;
    mop = 3'd0;
    run_instr(8'h55, 1'b0, 8, -1, 0, "midrst_restart");
  endtask

  task automatic test_hlt();
    logic [4:0]  opnd;
    logic [4:0]  pc0;
    logic [16:0] exp_v, got;
    run_instr(8'hF4, 1'b0, 8, -1, 0, "hlt_jmp20");
    opnd = 5'($urandom);
    pc0  = mpc;
    bus.data_in = {3'd0, opnd};
    for (int k = 0; k < 5; k++) begin
      zero  = 1'($urandom);
      exp_v = {(k < 3) ? mop : 3'd0, (k < 4) ? pc0 : opnd,
               (k >= 1 && k <= 3), 1'b0, 1'b0, pc0, 1'b0};
      got = observed();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL hlt_entry cycle=%0d: got %h expected %h", k, got, exp_v);
      end
      @(negedge clk);
    end
    exp_v = {3'd0, opnd, 1'b0, 1'b0, 1'b0, pc0 + 5'd1, 1'b1};
    for (int k = 0; k < 22; k++) begin
      zero = 1'($urandom);
      bus.data_in = 8'($urandom);
      got = observed();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL halted cycle=%0d: got %h expected %h", k, got, exp_v);
      end
      @(negedge clk);
    end
    do_reset("hlt_reset");
    run_instr(8'hC2, 1'b0, 8, -1, 0, "hlt_restart");
  endtask

  initial begin
    rst         = 1'b1;
    zero        = 1'b0;
    bus.data_in = 8'h00;
`ifdef SEQ_STALL_EN
    bus.mem_ready = 1'b1;
`endif
    mpc = 5'd0;
    mop = 3'd0;
    test_reset();
    test_add();
    test_skz();
    test_jmp_sto();
    test_back_to_back();
`ifdef SEQ_STALL_EN
    test_stall();
`endif
    test_mid_reset();
    test_hlt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_control.md
# seq_control

Instruction sequencer for the 8-bit accumulator CPU. It fetches each instruction byte from memory, latches it into an internal instruction register, and walks a fixed 8-phase state machine. In each phase it drives the memory strobes, the program counter, the accumulator load enable and the `opcode_t` value consumed by the ALU. It sits directly upstream of the ALU: its `opcode` output is the ALU's `opcode` input, and it consumes the ALU's `zero` flag for SKZ.

## Interface
- `PC_W`, default 5: program counter and operand address width; `2**PC_W` memory locations.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: **synchronous, active-high** reset, sampled on posedge `clk`.
- `data_in` in 8: memory read data; bits [7:5] are the opcode, bits [4:0] the operand address.
- `zero` in 1: ALU zero flag; 1 when the accumulator is 0.
- `mem_ready` in 1: memory handshake. Present only with `SEQ_STALL_EN`.
- `opcode` out `opcode_t`: current IR opcode, fed to the ALU.
- `mem_addr` out `PC_W`: memory address.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `load_ac` out 1: accumulator load enable.
- `pc` out `PC_W`: program counter, for debug and observation.
- `halt` out 1: sticky; set by HLT.

## Operation
- Phases, one per clock, in order: INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR. An extra terminal state, HALTED, is reachable only from OP_ADDR.
- `aluop` means the opcode is one of ADD, AND, XOR or LDA.
- Outputs are Moore, decoded from state and IR:
  - INST_ADDR: all strobes 0.
  - INST_FETCH: `mem_rd`=1.
  - INST_LOAD: `mem_rd`=1; IR ← `data_in` at the end of the cycle.
  - IDLE: `mem_rd`=1.
  - OP_ADDR: PC ← PC+1 at the end of the cycle. If IR opcode is HLT, next state is HALTED instead of OP_FETCH.
  - OP_FETCH: `mem_rd`=`aluop`.
  - ALU_OP: `mem_rd`=`aluop`, `load_ac`=`aluop`.
    - SKZ with `zero`=1: PC ← PC+1.
    - JMP: PC ← IR[4:0].
  - STORE: `mem_rd`=`aluop`, `load_ac`=`aluop`, `mem_wr`=(opcode==STO).
  - HALTED: all strobes 0, `halt`=1. The state is held until `rst`.
- `mem_addr` is `pc` in INST_ADDR..IDLE and IR[4:0] in OP_ADDR..STORE and HALTED.
- `opcode` always equals IR[7:5].
- PC arithmetic is modulo `2**PC_W`: 31+1 → 0 with `PC_W`=5. The SKZ skip also wraps.
- `zero` is sampled only in ALU_OP; it is ignored in every other state.
- Reset wins over every other event, in any state and mid-instruction. Reset values:
  - state = INST_ADDR;
  - PC = 0;
  - IR = 0, so `opcode` = HLT;
  - `mem_rd`, `mem_wr`, `load_ac`, `halt` = 0;
  - `mem_addr` = 0.

## Timing
- Every instruction takes exactly 8 clocks when there is no stall. HLT takes 5 clocks to reach HALTED.
- IR is valid from the first cycle of IDLE.
- The ALU sees `opcode` at least 3 clocks before its negedge evaluation in ALU_OP.
- PC changes are visible in the cycle after OP_ADDR and in the cycle after ALU_OP.
- The first reset-release posedge produces INST_ADDR with `mem_addr`=0.

## Configuration
- Macro: `SEQ_STALL_EN`.
- When defined:
  - The `mem_ready` port exists.
  - In any state asserting `mem_rd` or `mem_wr`, the FSM holds while `mem_ready`=0. Outputs stay constant and PC and IR are not updated.
  - IR captures only on the INST_LOAD cycle where `mem_ready`=1.
  - Reset still wins over a stall.
- When undefined: the port is absent, behaviour is as if `mem_ready`=1, and timing is a fixed 8 clocks per instruction.

## Structure
- `typedefs_v2` package holds:
  - `opcode_t` (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7);
  - new `seq_state_t` enum: the 8 phases plus HALTED.
- The PC is naturally a separate sub-module, `seq_pc`, containing:
  - a `PC_W`-bit counter with synchronous reset, increment and load;
  - load priority over increment.

## Test plan
- **Reset then run.** After `rst` 1→0, expect INST_ADDR, `mem_addr`=0, all strobes 0. `mem_rd`=1 follows on cycles 2–4.
- **ADD.** Fetch `data_in`=8'h4A (ADD, addr 10) at PC 3. Expect:
  - `opcode`=ADD from IDLE;
  - `mem_addr`=10 in OP_ADDR..STORE;
  - `load_ac`=1 in ALU_OP and STORE;
  - PC=4 at the next INST_ADDR.
- **SKZ.** Instruction 8'h20 at PC 7:
  - `zero`=1 in ALU_OP → next fetch from PC 9;
  - `zero`=0 → next fetch from PC 8;
  - at PC 31 with `zero`=1 → next fetch from PC 1.
- **JMP and STO.**
  - 8'hE5 (JMP 5) → next INST_ADDR `mem_addr`=5, `mem_wr` never set.
  - 8'hC9 (STO 9) → `mem_wr`=1 only in STORE, with `mem_addr`=9.
- **HLT.** 8'h00 → HALTED entered after OP_ADDR. Check:
  - `halt`=1 and no strobes for 20+ clocks;
  - `rst` pulse clears `halt` and restarts at PC 0.
- **Stall (`SEQ_STALL_EN`) and mid-instruction reset.**
  - `mem_ready`=0 for 3 clocks in INST_FETCH → outputs frozen and instruction takes 11 clocks.
  - `rst`=1 during ALU_OP of an ADD → no `load_ac` on the next clock and state is INST_ADDR.
